// File: rtl/gf2m_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gf2m_pkg
//  Brief    : Shared constants, types and the reference squaring function for
//             the GF(2^M) repeated-squaring unit.
//  Revision : 1.0 - initial release
// ============================================================================
package gf2m_pkg;

  // Default field: sect163, x^163 + x^7 + x^6 + x^3 + 1
  localparam int                M_DEF    = 163;
  localparam logic [M_DEF-1:0]  POLY_DEF = 163'h0C9;

  typedef logic [M_DEF-1:0] gf_elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Squaring in the default-degree field: spread bits to even positions,
  // then fold every coefficient at or above x^M back down using POLY.
  function automatic gf_elem_t gf_sqr(gf_elem_t elem, gf_elem_t poly);
    logic [2*M_DEF-2:0] t;
    t = '0;
    for (int i = 0; i < M_DEF; i++) begin
      t[2*i] = elem[i];
    end
    for (int i = 2*M_DEF-2; i >= M_DEF; i--) begin
      if (t[i]) begin
        t[i]                = 1'b0;
        t[i-M_DEF +: M_DEF] = t[i-M_DEF +: M_DEF] ^ poly;
      end
    end
    return t[M_DEF-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf2m_sqr_comb.sv
`default_nettype none
// ============================================================================
//  Module   : gf2m_sqr_comb
//  Brief    : Single combinational GF(2^M) squarer, polynomial basis,
//             reduction modulo x^M + POLY.
//  Revision : 1.0 - initial release
// ============================================================================
module gf2m_sqr_comb
  import gf2m_pkg::*;
#(
  parameter int           M    = M_DEF,
  parameter logic [M-1:0] POLY = POLY_DEF
) (
  input  logic [M-1:0] x_i,
  output logic [M-1:0] y_o
);

  logic [2*M-2:0] w_wide;

  // Spread then reduce from the top down; each fold only touches lower
  // positions, so a single descending pass clears all bits >= M.
  always_comb begin
    w_wide = '0;
    for (int i = 0; i < M; i++) begin
      w_wide[2*i] = x_i[i];
    end
    for (int i = 2*M-2; i >= M; i--) begin
      if (w_wide[i]) begin
        w_wide[i]        = 1'b0;
        w_wide[i-M +: M] = w_wide[i-M +: M] ^ POLY;
      end
    end
    y_o = w_wide[M-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/gf2m_multi_square.sv
`default_nettype none
// ============================================================================
//  Module   : gf2m_multi_square
//  Brief    : Iterative GF(2^M) repeated squarer, B = A^(2^k), U squarings
//             per RUN cycle, start/done handshake with synchronous abort.
//  Revision : 1.0 - initial release
// ============================================================================
module gf2m_multi_square
  import gf2m_pkg::*;
#(
  parameter int           M     = M_DEF,
  parameter logic [M-1:0] POLY  = POLY_DEF,
  parameter int           U     = 1,
  parameter int           CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [M-1:0]     a_i,
  input  logic [CNT_W-1:0] k_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [M-1:0]     b_o
);

  localparam logic [CNT_W-1:0] U_CNT = CNT_W'(U);

  fsm_state_e       state_q, state_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [M-1:0]     w_stage [U+1];
  logic [M-1:0]     w_sel;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_rem_next;

  // Squarer chain: stage j holds acc^(2^j)
  assign w_stage[0] = acc_q;

  generate
    for (genvar g = 0; g < U; g++) begin : g_stage
      gf2m_sqr_comb #(
        .M    (M),
        .POLY (POLY)
      ) u_sqr (
        .x_i (w_stage[g]),
        .y_o (w_stage[g+1])
      );
    end
  endgenerate

  // Steps this cycle: never more than what remains, so rem cannot underflow
  always_comb begin
    w_n        = (rem_q < U_CNT) ? rem_q : U_CNT;
    w_rem_next = rem_q - w_n;
  end

  // Pick the chain tap matching the step count so a short final step is exact
  always_comb begin
    w_sel = w_stage[0];
    for (int j = 1; j <= U; j++) begin
      if (w_n == CNT_W'(j)) begin
        w_sel = w_stage[j];
      end
    end
  end

  // Next-state logic: accept in IDLE/DONE, iterate in RUN, abort wins over rem update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          acc_d   = a_i;
          rem_d   = k_i;
          state_d = (k_i != '0) ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = w_sel;
          rem_d   = w_rem_next;
          state_d = (w_rem_next == '0) ? DONE : RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and remaining-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  assign ready_o = (state_q != RUN);
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign b_o     = acc_q;

endmodule
`default_nettype wire
